coso_health_monitor: RTL and testbench

Online health-test and byte-packing stage that consumes raw bits from the coherent sampler and feeds the transmit path. It watches the sampler request, captures the counter LSB per sample, and runs a repetition-count test (RCT) and an adaptive-proportion test (APT) on the bit stream. Health-checked bits are packed into bytes and offered on a valid/ready port to the sample-to-transmit controller. Any test failure raises a sticky alarm and stops byte output.

---
 rtl/coso_pkg.sv | 10 +
 rtl/req_sync_edge.sv | 26 ++
 rtl/coso_health_monitor.sv | 147 ++++++++++++++
 tb/tb_coso_health_monitor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coso_pkg.sv
// Shared constants for the coherent-sampler health monitor: health-test
// defaults and the packed byte width.
package coso_pkg;

  localparam int RCT_CUTOFF     = 32;
  localparam int APT_WINDOW_LOG = 10;
  localparam int APT_CUTOFF     = 589;
  localparam int BYTE_W         = 8;

endpackage

// File: rtl/req_sync_edge.sv
// Two-flop synchronizer for an asynchronous request followed by a registered
// rising-edge detector; emits a one-cycle pulse per request.
module req_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic pulse
);

  logic [1:0] sync;
  logic       prev;

  // NOTE: non-blocking assignments make each flop sample pre-edge values, so this is a true shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], req};
      prev  <= sync[1];
      pulse <= sync[1] & ~prev;
    end
  end

endmodule

// File: rtl/coso_health_monitor.sv
// Health-test (RCT + APT) and byte-packing stage between the coherent sampler
// and the transmit path. Any test failure raises a sticky alarm.
module coso_health_monitor #(
  parameter int RCT_CUTOFF     = coso_pkg::RCT_CUTOFF,
  parameter int APT_WINDOW_LOG = coso_pkg::APT_WINDOW_LOG,
  parameter int APT_CUTOFF     = coso_pkg::APT_CUTOFF,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CSReq,
  input  logic [CNT_WIDTH-1:0] CSCnt,
  input  logic                 enable,
  input  logic                 byte_ready,
  output logic [7:0]           rand_byte,
  output logic                 byte_valid,
  output logic                 rct_fail,
  output logic                 apt_fail,
  output logic                 alarm,
  output logic [7:0]           drop_cnt
);

  import coso_pkg::*;

  localparam int RUN_W   = $clog2(RCT_CUTOFF + 1);
  localparam int MATCH_W = APT_WINDOW_LOG + 1;
  localparam int BCNT_W  = $clog2(BYTE_W);

  logic sample_pulse;
  logic event_ok;
  logic b;
  logic unused_cnt;

  req_sync_edge u_req_sync (
    .clk   (clk),
    .rst   (rst),
    .req   (CSReq),
    .pulse (sample_pulse)
  );

  assign b          = CSCnt[0];
  assign unused_cnt = ^CSCnt[CNT_WIDTH-1:1];
  assign alarm      = rct_fail | apt_fail;
  assign event_ok   = sample_pulse & enable & ~alarm;

  // Repetition-count test state and next-state
  logic             last_bit;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic             rct_hit;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch appears.
  always_comb begin
    run_next = RUN_W'(1);
    if (run_cnt != '0 && b == last_bit) begin
      run_next = (run_cnt == RUN_W'(RCT_CUTOFF)) ? run_cnt : run_cnt + 1'b1;
    end
  end

  assign rct_hit = event_ok & (run_next == RUN_W'(RCT_CUTOFF));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_bit <= 1'b0;
      run_cnt  <= '0;
      rct_fail <= 1'b0;
    end else if (event_ok) begin
      last_bit <= b;
      run_cnt  <= run_next;
      if (rct_hit) rct_fail <= 1'b1;
    end
  end

  // Adaptive-proportion test over a 2^APT_WINDOW_LOG bit window
  logic [APT_WINDOW_LOG-1:0] win_pos;
  logic                      ref_bit;
  logic [MATCH_W-1:0]        match_cnt;
  logic [MATCH_W-1:0]        match_next;
  logic                      apt_hit;

  always_comb begin
    match_next = match_cnt;
    if (win_pos == '0) begin
      match_next = MATCH_W'(1);
    end else if (b == ref_bit) begin
      match_next = match_cnt + 1'b1;
    end
  end

  assign apt_hit = event_ok & (match_next == MATCH_W'(APT_CUTOFF));

  always_ff @(posedge clk) begin
    if (rst) begin
      win_pos   <= '0;
      ref_bit   <= 1'b0;
      match_cnt <= '0;
      apt_fail  <= 1'b0;
    end else if (event_ok) begin
      win_pos   <= win_pos + 1'b1;
      match_cnt <= match_next;
      if (win_pos == '0) ref_bit <= b;
      if (apt_hit) apt_fail <= 1'b1;
    end
  end

  // Packer: the failing bit is never packed
  logic [BYTE_W-1:0] shift_reg;
  logic [BCNT_W-1:0] bit_cnt;
  logic              pack_ok;
  logic              byte_done;
  logic [BYTE_W-1:0] new_byte;

  assign pack_ok   = event_ok & ~rct_hit & ~apt_hit;
  assign byte_done = pack_ok & (bit_cnt == BCNT_W'(BYTE_W - 1));
  assign new_byte  = {b, shift_reg[BYTE_W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (pack_ok) begin
      shift_reg <= new_byte;
      bit_cnt   <= bit_cnt + 1'b1;
    end
  end

  // Output register is never overwritten while a byte is still waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      rand_byte  <= '0;
      byte_valid <= 1'b0;
      drop_cnt   <= '0;
    end else if (alarm) begin
      byte_valid <= 1'b0;
    end else if (byte_done) begin
      if (byte_valid && !byte_ready) begin
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else begin
        rand_byte  <= new_byte;
        byte_valid <= 1'b1;
      end
    end else if (byte_valid && byte_ready) begin
      byte_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coso_health_monitor.sv
// Directed bench for coso_health_monitor: a behavioural model predicts bytes
// and test flags; transferred bytes are checked against a scoreboard queue.
module tb_coso_health_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        CSReq;
  logic [15:0] CSCnt;
  logic        enable;
  logic        byte_ready;
  logic [7:0]  rand_byte;
  logic        byte_valid;
  logic        rct_fail;
  logic        apt_fail;
  logic        alarm;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_base = 0;

  // Behavioural model state
  logic       mdl_last, mdl_ref, mdl_rct, mdl_apt, mdl_held;
  int         mdl_run, mdl_pos, mdl_match, mdl_n, mdl_drop;
  logic [7:0] mdl_sh;

  coso_health_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .CSReq      (CSReq),
    .CSCnt      (CSCnt),
    .enable     (enable),
    .byte_ready (byte_ready),
    .rand_byte  (rand_byte),
    .byte_valid (byte_valid),
    .rct_fail   (rct_fail),
    .apt_fail   (apt_fail),
    .alarm      (alarm),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) obs_q.push_back(rand_byte);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pat(input int i, input int n);
    return ((i * n) % 1024) < n;
  endfunction

  task automatic model_clear();
    mdl_last = 1'b0; mdl_ref = 1'b0; mdl_rct = 1'b0; mdl_apt = 1'b0; mdl_held = 1'b0;
    mdl_run = 0; mdl_pos = 0; mdl_match = 0; mdl_n = 0; mdl_drop = 0; mdl_sh = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    CSReq = 1'b1;
    @(posedge clk); #1 CSReq = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    model_clear();
  endtask

  // One sampler request carrying bit b; returns one cycle after the capture edge.
  task automatic do_req(input logic b);
    logic       pushed;
    logic [7:0] nb;
    pushed = 1'b0;
    nb = '0;
    if (enable && !mdl_rct && !mdl_apt) begin
      if (mdl_run > 0 && b == mdl_last) begin
        if (mdl_run < 32) mdl_run++;
      end else begin
        mdl_last = b;
        mdl_run = 1;
      end
      if (mdl_pos == 0) begin
        mdl_ref = b;
        mdl_match = 1;
      end else if (b == mdl_ref) begin
        mdl_match++;
      end
      mdl_pos = (mdl_pos + 1) % 1024;
      if (mdl_run == 32) mdl_rct = 1'b1;
      if (mdl_match == 589) mdl_apt = 1'b1;
      if (mdl_rct || mdl_apt) begin
        if (mdl_held) begin
          void'(exp_q.pop_back());
          mdl_held = 1'b0;
        end
      end else begin
        mdl_sh[mdl_n] = b;
        mdl_n++;
        if (mdl_n == 8) begin
          mdl_n = 0;
          if (mdl_held && !byte_ready) begin
            if (mdl_drop < 255) mdl_drop++;
          end else begin
            exp_q.push_back(mdl_sh);
            pushed = 1'b1;
            nb = mdl_sh;
            if (!byte_ready) mdl_held = 1'b1;
          end
        end
      end
    end
    CSCnt = {15'($urandom), b};
    CSReq = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 CSReq = 1'b0;
    @(posedge clk); #1;
    if (pushed && byte_ready) check("valid_before_latency", 32'(byte_valid), 32'd0);
    @(posedge clk); #1;
    if (pushed && byte_ready) begin
      check("valid_at_latency", 32'(byte_valid), 32'd1);
      check("byte_at_latency", 32'(rand_byte), 32'(nb));
    end
    check("rct_fail", 32'(rct_fail), 32'(mdl_rct));
    check("apt_fail", 32'(apt_fail), 32'(mdl_apt));
    check("alarm", 32'(alarm), 32'(mdl_rct | mdl_apt));
    check("drop_cnt", 32'(drop_cnt), 32'(mdl_drop));
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) do_req(v[k]);
  endtask

  task automatic compare_sb(input string tag);
    int n;
    @(posedge clk); #1;
    n = obs_q.size() - obs_base;
    check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(obs_q[obs_base + i]), 32'(exp_q[i]));
    end
    obs_base = obs_q.size();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    CSReq = 1'b0;
    CSCnt = '0;
    enable = 1'b1;
    byte_ready = 1'b1;
    model_clear();

    // Reset values, with CSReq toggling during reset
    do_reset();
    check("rst_rand_byte", 32'(rand_byte), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_rct_fail", 32'(rct_fail), 32'd0);
    check("rst_apt_fail", 32'(apt_fail), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    repeat (6) @(posedge clk);
    #1 check("rst_no_capture", 32'(byte_valid), 32'd0);

    // Packing and latency: alternating bits give 0x55 twice
    for (int i = 0; i < 16; i++) do_req(i % 2 == 0);
    @(posedge clk); #1 check("pack_valid_one_cycle", 32'(byte_valid), 32'd0);
    check("pack_alarm", 32'(alarm), 32'd0);
    check("pack_exp_is_55", 32'(exp_q.size() == 2 && exp_q[0] == 8'h55 && exp_q[1] == 8'h55), 32'd1);
    compare_sb("pack");

    // Reset mid-byte discards the partial byte
    do_req(1'b1); do_req(1'b1); do_req(1'b0);
    do_reset();
    send_byte(8'hC3);
    compare_sb("rst_partial");

    // Enable gating in the middle of a byte, then continue into an RCT trip
    do_reset();
    do_req(1'b1); do_req(1'b0); do_req(1'b1); do_req(1'b1);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) do_req(i % 2 == 1);
    enable = 1'b1;
    for (int i = 0; i < 34; i++) do_req(1'b1);
    check("gate_first_byte", 32'(obs_q[obs_base]), 32'h0000_00FD);
    compare_sb("gate");

    // RCT trip: 32 ones, three 0xFF bytes, nothing afterwards
    do_reset();
    for (int i = 0; i < 40; i++) do_req(1'b1);
    check("rct_bytes", 32'(obs_q.size() - obs_base), 32'd3);
    check("rct_only", 32'(apt_fail), 32'd0);
    compare_sb("rct");

    // Alarm withdraws a held byte on the following cycle
    do_reset();
    byte_ready = 1'b0;
    for (int i = 0; i < 32; i++) do_req(1'b1);
    check("held_valid_at_alarm", 32'(byte_valid), 32'd1);
    check("held_byte_at_alarm", 32'(rand_byte), 32'h0000_00FF);
    @(posedge clk); #1 check("valid_withdrawn", 32'(byte_valid), 32'd0);
    byte_ready = 1'b1;
    mdl_held = 1'b0;
    compare_sb("withdraw");

    // APT trip: 589 ones in the window, first bit 1
    do_reset();
    for (int i = 0; i < 1024; i++) do_req(pat(i, 589));
    check("apt589_fail", 32'(apt_fail), 32'd1);
    check("apt589_no_rct", 32'(rct_fail), 32'd0);
    compare_sb("apt589");

    // 588 ones passes; the next window restarts with reference bit 0
    do_reset();
    for (int i = 0; i < 1024; i++) do_req(pat(i, 588));
    check("apt588_pass", 32'(apt_fail), 32'd0);
    for (int i = 0; i < 1024; i++) do_req(!pat(i, 589));
    check("apt_window2_fail", 32'(apt_fail), 32'd1);
    compare_sb("apt588");

    // Back-pressure: first byte held, next two dropped, then released unchanged
    do_reset();
    byte_ready = 1'b0;
    send_byte(8'h3C);
    send_byte(8'hC3);
    send_byte(8'h5A);
    check("bp_valid_held", 32'(byte_valid), 32'd1);
    check("bp_byte_held", 32'(rand_byte), 32'h0000_003C);
    check("bp_drop_cnt", 32'(drop_cnt), 32'd2);
    byte_ready = 1'b1;
    mdl_held = 1'b0;
    @(posedge clk); #1 check("bp_valid_released", 32'(byte_valid), 32'd0);
    compare_sb("bp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
